// File: rtl/axi_lite_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_read_arbiter
// Purpose  : Shares one AXI4-Lite read port (AR/R) between two masters,
//            m0 (instruction fetch) and m1 (load/store). One outstanding read
//            at a time; round-robin between the masters when both request in
//            the same cycle. The grant is held from AR issue until the R
//            handshake completes.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            i_m0_* / o_m0_*     - master 0 AR/R channels
//            i_m1_* / o_m1_*     - master 1 AR/R channels
//            o_s_*  / i_s_*      - shared slave AR/R channels
//            o_grant             - one-hot owner (bit0 = m0, bit1 = m1), 0 idle
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // master 0
  input  logic              i_m0_arvalid,
  output logic              o_m0_arready,
  input  logic [ADDR_W-1:0] i_m0_araddr,
  output logic              o_m0_rvalid,
  input  logic              i_m0_rready,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic [1:0]        o_m0_rresp,
  // master 1
  input  logic              i_m1_arvalid,
  output logic              o_m1_arready,
  input  logic [ADDR_W-1:0] i_m1_araddr,
  output logic              o_m1_rvalid,
  input  logic              i_m1_rready,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [1:0]        o_m1_rresp,
  // shared slave port
  output logic              o_s_arvalid,
  input  logic              i_s_arready,
  output logic [ADDR_W-1:0] o_s_araddr,
  input  logic              i_s_rvalid,
  output logic              o_s_rready,
  input  logic [DATA_W-1:0] i_s_rdata,
  input  logic [1:0]        i_s_rresp,
  // current owner
  output logic [1:0]        o_grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_owner, w_owner_nxt;   // 0 = m0, 1 = m1
  logic        r_last,  w_last_nxt;    // master served most recently
  logic [1:0]  r_grant, w_grant_nxt;
  logic        w_arvalid;
  logic        w_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;                  // m0 wins the first tie
      r_grant <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_last_nxt   = r_last;
    w_grant_nxt  = r_grant;
    w_arvalid    = 1'b0;
    w_rready     = 1'b0;
    o_m0_arready = 1'b0;
    o_m0_rvalid  = 1'b0;
    o_m0_rdata   = '0;
    o_m0_rresp   = 2'b00;
    o_m1_arready = 1'b0;
    o_m1_rvalid  = 1'b0;
    o_m1_rdata   = '0;
    o_m1_rresp   = 2'b00;
    o_s_arvalid  = 1'b0;
    o_s_araddr   = '0;
    o_s_rready   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_m0_arvalid || i_m1_arvalid) begin
          // On a tie the master that was not served last wins.
          w_owner_nxt = (i_m0_arvalid && i_m1_arvalid) ? ~r_last : i_m1_arvalid;
          w_grant_nxt = w_owner_nxt ? 2'b10 : 2'b01;
          w_state_nxt = ST_ADDR;
        end
      end

      ST_ADDR: begin
        // Address is passed through, not latched: masters hold it until arready.
        if (r_owner) begin
          w_arvalid    = i_m1_arvalid;
          o_s_araddr   = i_m1_araddr;
          o_m1_arready = i_s_arready;
        end else begin
          w_arvalid    = i_m0_arvalid;
          o_s_araddr   = i_m0_araddr;
          o_m0_arready = i_s_arready;
        end
        o_s_arvalid = w_arvalid;
        if (w_arvalid && i_s_arready) begin
          w_state_nxt = ST_DATA;
        end
      end

      ST_DATA: begin
        if (r_owner) begin
          w_rready    = i_m1_rready;
          o_m1_rvalid = i_s_rvalid;
          o_m1_rdata  = i_s_rdata;
          o_m1_rresp  = i_s_rresp;
        end else begin
          w_rready    = i_m0_rready;
          o_m0_rvalid = i_s_rvalid;
          o_m0_rdata  = i_s_rdata;
          o_m0_rresp  = i_s_rresp;
        end
        o_s_rready = w_rready;
        if (i_s_rvalid && w_rready) begin
          w_last_nxt  = r_owner;
          w_grant_nxt = 2'b00;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase
  end

  assign o_grant = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_read_arbiter
// Purpose  : Directed self-checking bench for axi_lite_read_arbiter. Inputs
//            change 1 time unit after the rising edge; outputs are checked
//            1 time unit later, well away from the next edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_arvalid, m0_rready, m1_arvalid, m1_rready;
  logic [31:0] m0_araddr, m1_araddr;
  logic        s_arready, s_rvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;

  logic        m0_arready, m0_rvalid, m1_arready, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        s_arvalid, s_rready;
  logic [31:0] s_araddr;
  logic [1:0]  grant;

  logic [107:0] all_out;
  assign all_out = {m0_arready, m0_rvalid, m0_rdata, m0_rresp,
                    m1_arready, m1_rvalid, m1_rdata, m1_rresp,
                    s_arvalid, s_araddr, s_rready, grant};

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_rvalid && s_rready) hs_cnt <= hs_cnt + 1;
  end

  axi_lite_read_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_m0_arvalid (m0_arvalid),
    .o_m0_arready (m0_arready),
    .i_m0_araddr  (m0_araddr),
    .o_m0_rvalid  (m0_rvalid),
    .i_m0_rready  (m0_rready),
    .o_m0_rdata   (m0_rdata),
    .o_m0_rresp   (m0_rresp),
    .i_m1_arvalid (m1_arvalid),
    .o_m1_arready (m1_arready),
    .i_m1_araddr  (m1_araddr),
    .o_m1_rvalid  (m1_rvalid),
    .i_m1_rready  (m1_rready),
    .o_m1_rdata   (m1_rdata),
    .o_m1_rresp   (m1_rresp),
    .o_s_arvalid  (s_arvalid),
    .i_s_arready  (s_arready),
    .o_s_araddr   (s_araddr),
    .i_s_rvalid   (s_rvalid),
    .o_s_rready   (s_rready),
    .i_s_rdata    (s_rdata),
    .i_s_rresp    (s_rresp),
    .o_grant      (grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    m0_arvalid = 1'b0; m0_araddr = '0; m0_rready = 1'b0;
    m1_arvalid = 1'b0; m1_araddr = '0; m1_rready = 1'b0;
    s_arready  = 1'b0; s_rvalid  = 1'b0; s_rdata = '0; s_rresp = 2'b00;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1'b1;
    s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b11; s_rvalid = 1'b1; s_arready = 1'b1;
    m0_rready = 1'b1; m1_rready = 1'b1;
    tick(); tick(); #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_out); end
    rst = 1'b0;
    clear_in();
    tick(); #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL idle_outputs got=%h want=0", all_out); end
  endtask

  task automatic test_single_m0();
    do_reset();
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0000; m0_rready = 1'b1;
    s_arready = 1'b1; #1;
    total++; if (s_arvalid !== 1'b0) begin bad++; $display("FAIL single_bubble got=%b want=0", s_arvalid); end
    tick(); #1;
    total++; if ({s_arvalid, s_araddr} !== {1'b1, 32'h8000_0000}) begin bad++; $display("FAIL single_ar got=%b/%h want=1/80000000", s_arvalid, s_araddr); end
    total++; if ({grant, m0_arready, m1_arready} !== 4'b0110) begin bad++; $display("FAIL single_grant got=%b want=0110", {grant, m0_arready, m1_arready}); end
    tick();
    m0_arvalid = 1'b0; s_arready = 1'b0; #1;
    total++; if ({s_arvalid, m0_rvalid, s_rready} !== 3'b001) begin bad++; $display("FAIL single_data_wait got=%b want=001", {s_arvalid, m0_rvalid, s_rready}); end
    tick();
    s_rvalid = 1'b1; s_rdata = 32'h0000_0413; s_rresp = 2'b00; #1;
    total++; if ({m0_rvalid, m0_rdata, m0_rresp, s_rready} !== {1'b1, 32'h0000_0413, 2'b00, 1'b1}) begin bad++; $display("FAIL single_r got=%b/%h/%b want=1/00000413/00", m0_rvalid, m0_rdata, m0_rresp); end
    total++; if ({m1_rvalid, m1_rdata, m1_rresp, m1_arready} !== 36'h0) begin bad++; $display("FAIL single_m1_quiet got=%b/%h want=0/0", m1_rvalid, m1_rdata); end
    tick();
    s_rvalid = 1'b0; #1;
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_release got=%b want=00", grant); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0004; m0_rready = 1'b1;
    m1_arvalid = 1'b1; m1_araddr = 32'hA000_03F8; m1_rready = 1'b1;
    s_arready = 1'b1; #1;
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL sim_idle_grant got=%b want=00", grant); end
    tick(); #1;
    total++; if ({grant, s_araddr} !== {2'b01, 32'h8000_0004}) begin bad++; $display("FAIL sim_first got=%b/%h want=01/80000004", grant, s_araddr); end
    tick();
    m0_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hAAAA_0001; #1;
    total++; if ({m0_rvalid, m0_rdata, m1_rvalid, m1_rdata} !== {1'b1, 32'hAAAA_0001, 1'b0, 32'h0}) begin bad++; $display("FAIL sim_r0 got=%b/%h %b/%h want=1/aaaa0001 0/0", m0_rvalid, m0_rdata, m1_rvalid, m1_rdata); end
    tick();
    s_rvalid = 1'b0; #1;
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL sim_gap got=%b want=00", grant); end
    tick(); #1;
    total++; if ({grant, s_araddr, m1_arready} !== {2'b10, 32'hA000_03F8, 1'b1}) begin bad++; $display("FAIL sim_second got=%b/%h want=10/a00003f8", grant, s_araddr); end
    tick();
    m1_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hBBBB_0002; #1;
    total++; if ({m1_rvalid, m1_rdata, m0_rvalid, m0_rdata} !== {1'b1, 32'hBBBB_0002, 1'b0, 32'h0}) begin bad++; $display("FAIL sim_r1 got=%b/%h %b/%h want=1/bbbb0002 0/0", m1_rvalid, m1_rdata, m0_rvalid, m0_rdata); end
    tick();
    s_rvalid = 1'b0; #1;
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL sim_release got=%b want=00", grant); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [31:0] exp_a;
    do_reset();
    m0_arvalid = 1'b1; m0_araddr = 32'h0000_1000; m0_rready = 1'b1;
    m1_arvalid = 1'b1; m1_araddr = 32'h0000_2000; m1_rready = 1'b1;
    s_arready = 1'b1; s_rvalid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000;
      s_rdata = 32'h100 + k; #1;
      total++; if ({grant, s_arvalid} !== 3'b000) begin bad++; $display("FAIL rr_idle[%0d] got=%b/%b want=00/0", k, grant, s_arvalid); end
      tick(); #1;
      total++; if ({grant, s_arvalid, s_araddr, s_rready} !== {exp_g, 1'b1, exp_a, 1'b0}) begin bad++; $display("FAIL rr_addr[%0d] got=%b/%h/%b want=%b/%h/0", k, grant, s_araddr, s_rready, exp_g, exp_a); end
      tick(); #1;
      if (exp_g == 2'b01) begin
        total++; if ({grant, m0_rvalid, m0_rdata, m1_rvalid} !== {2'b01, 1'b1, 32'h100 + k, 1'b0}) begin bad++; $display("FAIL rr_data[%0d] got=%b/%b/%h want=01/1/%h", k, grant, m0_rvalid, m0_rdata, 32'h100 + k); end
      end else begin
        total++; if ({grant, m1_rvalid, m1_rdata, m0_rvalid} !== {2'b10, 1'b1, 32'h100 + k, 1'b0}) begin bad++; $display("FAIL rr_data[%0d] got=%b/%b/%h want=10/1/%h", k, grant, m1_rvalid, m1_rdata, 32'h100 + k); end
      end
      tick();
    end
    clear_in(); #1;
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL rr_end got=%b want=00", grant); end
  endtask

  task automatic test_backpressure();
    int base;
    base = hs_cnt;
    clear_in();
    m1_arvalid = 1'b1; m1_araddr = 32'h1234_5678; m1_rready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({s_arvalid, s_araddr, m1_arready, grant} !== {1'b1, 32'h1234_5678, 1'b0, 2'b10}) begin bad++; $display("FAIL bp_ar_hold[%0d] got=%b/%h/%b want=1/12345678/0", i, s_arvalid, s_araddr, m1_arready); end
      tick();
    end
    s_arready = 1'b1; #1;
    total++; if (m1_arready !== 1'b1) begin bad++; $display("FAIL bp_arready got=%b want=1", m1_arready); end
    tick();
    m1_arvalid = 1'b0; s_arready = 1'b0; m1_rready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({s_rready, m1_rvalid, grant} !== 4'b0110) begin bad++; $display("FAIL bp_r_hold[%0d] got=%b want=0110", i, {s_rready, m1_rvalid, grant}); end
      tick();
    end
    m1_rready = 1'b1; #1;
    total++; if ({s_rready, m1_rdata} !== {1'b1, 32'h5555_AAAA}) begin bad++; $display("FAIL bp_r_go got=%b/%h want=1/5555aaaa", s_rready, m1_rdata); end
    tick();
    s_rvalid = 1'b0; #1;
    total++; if (hs_cnt - base !== 1) begin bad++; $display("FAIL bp_handshakes got=%0d want=1", hs_cnt - base); end
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL bp_release got=%b want=00", grant); end
  endtask

  task automatic test_error_stray();
    clear_in();
    m1_arvalid = 1'b1; m1_araddr = 32'h0000_0040; m1_rready = 1'b1;
    tick();
    // AR and R offered together in the address phase: only AR is taken.
    s_arready = 1'b1; s_rvalid = 1'b1; s_rresp = 2'b10; s_rdata = 32'hE0E0_E0E0; #1;
    total++; if ({s_rready, m1_rvalid, m1_arready} !== 3'b001) begin bad++; $display("FAIL err_ar_only got=%b want=001", {s_rready, m1_rvalid, m1_arready}); end
    tick();
    m1_arvalid = 1'b0; s_arready = 1'b0; #1;
    total++; if ({m1_rvalid, m1_rresp, m1_rdata} !== {1'b1, 2'b10, 32'hE0E0_E0E0}) begin bad++; $display("FAIL err_rresp got=%b/%b want=1/10", m1_rvalid, m1_rresp); end
    tick();
    s_rvalid = 1'b0; s_rresp = 2'b00; tick();
    s_rvalid = 1'b1; s_rdata = 32'h7777_7777; #1;
    total++; if ({s_rready, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== 67'h0) begin bad++; $display("FAIL stray_ignored got=%b/%b/%b want=0/0/0", s_rready, m0_rvalid, m1_rvalid); end
    tick();
    s_rvalid = 1'b0; #1;
    total++; if ({grant, s_arvalid} !== 3'b000) begin bad++; $display("FAIL stray_state got=%b/%b want=00/0", grant, s_arvalid); end
  endtask

  task automatic test_reset_mid();
    clear_in();
    m0_arvalid = 1'b1; m0_araddr = 32'h0000_0800; m0_rready = 1'b1; s_arready = 1'b1;
    tick(); tick();
    m0_arvalid = 1'b0; s_arready = 1'b0; #1;
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL mid_in_data got=%b want=01", grant); end
    rst = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h1111_2222;
    tick(); #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL mid_reset_outputs got=%h want=0", all_out); end
    rst = 1'b0; s_rvalid = 1'b0;
    m1_arvalid = 1'b1; m1_araddr = 32'h0000_0C00; m1_rready = 1'b1; s_arready = 1'b1;
    tick(); #1;
    total++; if ({grant, s_araddr} !== {2'b10, 32'h0000_0C00}) begin bad++; $display("FAIL mid_regrant got=%b/%h want=10/00000c00", grant, s_araddr); end
    tick();
    m1_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0000_00C1; #1;
    total++; if ({m1_rvalid, m1_rdata} !== {1'b1, 32'h0000_00C1}) begin bad++; $display("FAIL mid_r got=%b/%h want=1/000000c1", m1_rvalid, m1_rdata); end
    tick();
    s_rvalid = 1'b0; #1;
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL mid_release got=%b want=00", grant); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    rst = 1'b1;
    test_reset();
    test_single_m0();
    test_simultaneous();
    test_round_robin();
    test_backpressure();
    test_error_stray();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
